// File: rtl/button_debouncer.sv
// Button debouncer: 2-flop synchroniser, four-state stability FSM, press/release pulses.
// Optional long-press detector compiled only with BUTTON_DEBOUNCER_LONG_PRESS_EN defined.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic long_press
);

  typedef enum logic [1:0] {
    IDLE_LO,
    WAIT_HI,
    IDLE_HI,
    WAIT_LO
  } state_t;

  localparam logic        RAW_INVERT = (ACTIVE_LOW != 0);
  localparam logic [23:0] DEB_LAST   = 24'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
    $error("button_debouncer: illegal DEBOUNCE_CYCLES/LONG_CYCLES combination");
  end

  logic        sync_meta;
  logic        sync;
  state_t      state;
  logic [23:0] stable_cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= btn_raw ^ RAW_INVERT;
      sync      <= sync_meta;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE_LO;
      stable_cnt  <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      case (state)
        IDLE_LO: begin
          if (sync) begin
            state      <= WAIT_HI;
            stable_cnt <= '0;
          end
        end
        WAIT_HI: begin
          if (!sync) begin
            state <= IDLE_LO;
          end else if (stable_cnt == DEB_LAST) begin
            state     <= IDLE_HI;
            btn_level <= 1'b1;
            btn_press <= 1'b1;
          end else begin
            stable_cnt <= stable_cnt + 24'd1;
          end
        end
        IDLE_HI: begin
          if (!sync) begin
            state      <= WAIT_LO;
            stable_cnt <= '0;
          end
        end
        WAIT_LO: begin
          if (sync) begin
            state <= IDLE_HI;
          end else if (stable_cnt == DEB_LAST) begin
            state       <= IDLE_LO;
            btn_level   <= 1'b0;
            btn_release <= 1'b1;
          end else begin
            stable_cnt <= stable_cnt + 24'd1;
          end
        end
        default: state <= IDLE_LO;
      endcase
    end
  end

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  localparam logic [27:0] HOLD_LAST = 28'(LONG_CYCLES - DEBOUNCE_CYCLES);

  logic [27:0] hold_cnt;
  logic        press_accept;

  assign press_accept = (state == WAIT_HI) && sync && (stable_cnt == DEB_LAST);

  // Cleared only on an accepted press, so a bounce back from WAIT_LO continues the same hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_cnt   <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (press_accept) begin
        hold_cnt <= '0;
      end else if ((state == IDLE_HI || state == WAIT_LO) && hold_cnt != HOLD_LAST) begin
        hold_cnt   <= hold_cnt + 28'd1;
        long_press <= (hold_cnt == HOLD_LAST - 28'd1);
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: expected pulses queued at stimulus time,
// popped and compared as the two instances (active-high and active-low) emit them.
module tb_button_debouncer;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int LAT  = DEB + 3;
  localparam int HOLD = LONG - DEB;

  typedef enum int {EV_PRESS, EV_RELEASE, EV_LONG} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       at;
  } ev_t;

  logic clk = 1'b0;
  logic resetn;
  logic raw0, raw1;
  logic level0, press0, release0, long0;
  logic level1, press1, release1, long1;

  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  ev_t  exp_q0[$];
  ev_t  exp_q1[$];

  button_debouncer #(.DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .ACTIVE_LOW(0)) dut (
    .clk(clk), .resetn(resetn), .btn_raw(raw0),
    .btn_level(level0), .btn_press(press0), .btn_release(release0), .long_press(long0)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .resetn(resetn), .btn_raw(raw1),
    .btn_level(level1), .btn_press(press1), .btn_release(release1), .long_press(long1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic expect_ev(input int d, input ev_kind_t k, input int at);
    ev_t e;
    e.kind = k;
    e.at   = at;
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic observe(input int d, input ev_kind_t k, input logic lvl);
    ev_t   e;
    int    depth;
    string nm;
    nm    = $sformatf("dut%0d_%s", d, k.name());
    depth = (d == 0) ? exp_q0.size() : exp_q1.size();
    if (depth == 0) begin
      check({nm, "_unexpected"}, 32'(depth), 32'd1);
      return;
    end
    e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    check({nm, "_kind"}, 32'(k), 32'(e.kind));
    check({nm, "_cycle"}, 32'(cyc), 32'(e.at));
    if (k == EV_PRESS)   check({nm, "_level"}, {31'd0, lvl}, 32'd1);
    if (k == EV_RELEASE) check({nm, "_level"}, {31'd0, lvl}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (press0 || release0) check("dut0_exclusive", {31'd0, press0 & release0}, 32'd0);
      if (press1 || release1) check("dut1_exclusive", {31'd0, press1 & release1}, 32'd0);
      if (press0)   observe(0, EV_PRESS, level0);
      if (release0) observe(0, EV_RELEASE, level0);
      if (long0)    observe(0, EV_LONG, level0);
      if (press1)   observe(1, EV_PRESS, level1);
      if (release1) observe(1, EV_RELEASE, level1);
      if (long1)    observe(1, EV_LONG, level1);
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_level0"},   {31'd0, level0},   32'd0);
    check({tag, "_press0"},   {31'd0, press0},   32'd0);
    check({tag, "_release0"}, {31'd0, release0}, 32'd0);
    check({tag, "_long0"},    {31'd0, long0},    32'd0);
    check({tag, "_level1"},   {31'd0, level1},   32'd0);
    check({tag, "_press1"},   {31'd0, press1},   32'd0);
    check({tag, "_release1"}, {31'd0, release1}, 32'd0);
    check({tag, "_long1"},    {31'd0, long1},    32'd0);
  endtask

  // Drive a new level on one instance and queue the pulses it must produce.
  task automatic drive(input int d, input logic v, input bit accepted);
    int t0;
    @(negedge clk);
    if (d == 0) raw0 = v;
    else        raw1 = v;
    t0 = cyc;
    if (accepted) begin
      if ((d == 0 && v) || (d == 1 && !v)) begin
        expect_ev(d, EV_PRESS, t0 + LAT);
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
        expect_ev(d, EV_LONG, t0 + LAT + HOLD);
`endif
      end else begin
        expect_ev(d, EV_RELEASE, t0 + LAT);
      end
    end
  endtask

  initial begin
    int t0;
    resetn = 1'b0;
    raw0   = 1'b0;
    raw1   = 1'b1;
    #3;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_level0", {31'd0, level0}, 32'd0);

    // Clean press held for 30 cycles, then release.
    drive(0, 1'b1, 1'b1);
    repeat (29) @(negedge clk);
    drive(0, 1'b0, 1'b1);
    repeat (15) @(negedge clk);
    check("after_release_level0", {31'd0, level0}, 32'd0);

    // Bounce: 2-cycle toggles for 40 cycles, then settle low; nothing may be accepted.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      raw0 = ((i / 2) % 2 == 0);
      check("bounce_level0", {31'd0, level0}, 32'd0);
    end
    raw0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("settle_level0", {31'd0, level0}, 32'd0);
    end

    // Reset asserted mid-debounce while the button stays held.
    drive(0, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #2 resetn = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    t0 = cyc;
    expect_ev(0, EV_PRESS, t0 + LAT);
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    expect_ev(0, EV_LONG, t0 + LAT + HOLD);
`endif
    repeat (30) @(negedge clk);
    drive(0, 1'b0, 1'b1);
    repeat (12) @(negedge clk);

    // Active-low instance: pin pulled low for a 100-cycle hold.
    drive(1, 1'b0, 1'b1);
    repeat (99) @(negedge clk);
    check("al_level1", {31'd0, level1}, 32'd1);
    drive(1, 1'b1, 1'b1);
    repeat (12) @(negedge clk);
    check("al_after_level1", {31'd0, level1}, 32'd0);

    check("dut0_leftover", 32'(exp_q0.size()), 32'd0);
    check("dut1_leftover", 32'(exp_q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the stable-sample count (in clk cycles) required to accept a level change; legal range 2..2^24-1.
REQ-002 SHALL have parameter LONG_CYCLES, default 100000000, meaning the held-high count (in clk cycles) that triggers long_press; legal range DEBOUNCE_CYCLES+1..2^28-1.
REQ-003 SHALL have parameter ACTIVE_LOW, default 0, meaning invert btn_raw before synchronisation when 1.
REQ-004 SHALL have port clk, input, 1, meaning the design clock from the board clock/reset generator; single clock domain.
REQ-005 SHALL have port resetn, input, 1, meaning the asynchronous active-low reset from the board clock/reset generator.
REQ-006 SHALL have port btn_raw, input, 1, meaning the asynchronous, bouncing board button pin.
REQ-007 SHALL have port btn_level, output, 1, meaning the debounced button state (1 = pressed).
REQ-008 SHALL have port btn_press, output, 1, meaning a one-cycle pulse on an accepted 0->1 transition.
REQ-009 SHALL have port btn_release, output, 1, meaning a one-cycle pulse on an accepted 1->0 transition.
REQ-010 SHALL have port long_press, output, 1, meaning a one-cycle pulse when the button has been held LONG_CYCLES.

Function
REQ-011 SHALL pass btn_raw (XOR ACTIVE_LOW) through a 2-flop synchroniser; only the second flop output (sync) is used downstream.
REQ-012 SHALL implement FSM states IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO with a 24-bit stability counter.
REQ-013 SHALL move IDLE_LO->WAIT_HI when sync=1, clearing the counter; IDLE_HI->WAIT_LO when sync=0, clearing the counter.
REQ-014 SHALL, in WAIT_HI, return to IDLE_LO when sync=0 (bounce), with no output pulse.
REQ-015 SHALL, in WAIT_HI, increment the counter while sync=1 and enter IDLE_HI on the cycle the counter equals DEBOUNCE_CYCLES-1.
REQ-016 SHALL apply REQ-014/REQ-015 symmetrically in WAIT_LO (return to IDLE_HI when sync=1; enter IDLE_LO on count).
REQ-017 SHALL drive btn_level registered: 1 in IDLE_HI and WAIT_LO, 0 in IDLE_LO and WAIT_HI.
REQ-018 SHALL assert btn_press for exactly the one cycle in which btn_level first reads 1; btn_release likewise on the first cycle btn_level reads 0.
REQ-019 SHALL give a latency of DEBOUNCE_CYCLES+3 clk edges from the first edge that samples a stable new btn_raw level to btn_level/pulse assertion.
REQ-020 SHALL never assert btn_press and btn_release in the same cycle, and never assert two consecutive btn_press pulses without an intervening btn_release.
REQ-021 SHALL saturate, not wrap, every counter; the counter never exceeds its terminal value.

Reset
REQ-022 SHALL, on resetn=0 (asynchronous), clear both synchroniser flops, the FSM (to IDLE_LO), all counters, btn_level, btn_press, btn_release and long_press to 0.
REQ-023 SHALL, on reset assertion mid-debounce or mid-press, discard the in-flight count with no pulse; after release, a held button re-qualifies from IDLE_LO and produces a fresh btn_press.
REQ-024 SHALL rely on the reset generator for deassertion timing; no internal reset synchroniser.

Configuration
REQ-025 SHALL compile the long-press detector only when macro BUTTON_DEBOUNCER_LONG_PRESS_EN is defined.
REQ-026 SHALL, with the macro defined, run a 28-bit hold counter cleared on entry to IDLE_HI, incrementing in IDLE_HI and WAIT_LO, pulsing long_press once when it reaches LONG_CYCLES-DEBOUNCE_CYCLES, then saturating until release.
REQ-027 SHALL, without the macro, tie long_press to constant 0 and omit the hold counter entirely.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=0)
REQ-028 SHALL verify that btn_raw 0->1 held stable gives btn_level=1 and a single btn_press exactly 7 edges later.
REQ-029 SHALL verify that btn_raw toggling every 2 cycles for 40 cycles then settling at 0 gives btn_level=0 throughout and no pulses.
REQ-030 SHALL verify that a press of 30 cycles followed by release gives btn_press, then btn_release 7 edges after the release; with the macro, long_press exactly once, 16 cycles after btn_press.
REQ-031 SHALL verify that resetn pulsed low during WAIT_HI with btn_raw held 1 gives all outputs 0 immediately, then btn_press 7 edges after resetn rises.
REQ-032 SHALL verify that with ACTIVE_LOW=1, btn_raw 1->0 held gives btn_press after 7 edges; without the macro, long_press stays 0 for a 100-cycle hold.
